// File: rtl/switch_pkg.sv
// Shared constants and the round-robin pick helper for the switch fabric.
//   DATA_WIDTH_DEF / INPUT_QTY_DEF / OUTPUT_QTY_DEF / FIFO_DEPTH_DEF : default sizing
//   RR_MAX   : widest request vector rr_pick can scan
//   rr_pick  : request vector + pointer + port count -> {valid, index}
package switch_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int INPUT_QTY_DEF  = 8;
    localparam int OUTPUT_QTY_DEF = 8;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int RR_MAX         = 64;

    typedef struct packed {
        logic        valid;
        logic [31:0] idx;
    } rr_pick_t;

    // Scan n request bits starting at ptr, wrapping at n; first hit wins.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                         input int unsigned       ptr,
                                         input int unsigned       n);
        rr_pick_t    res;
        int unsigned cand;
        res.valid = 1'b0;
        res.idx   = 32'd0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            if (k < n) begin
                cand = ptr + k;
                if (cand >= n) begin
                    cand = cand - n;
                end else begin
                    cand = cand;
                end
                if (!res.valid && req[cand[5:0]]) begin
                    res.valid = 1'b1;
                    res.idx   = cand;
                end else begin
                    res = res;
                end
            end else begin
                cand = 32'd0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo.sv
// Show-ahead FIFO, no write-to-read bypass: a word written in cycle N is at the
// head in N+1.  Push while full and pop while empty are ignored.
//   clk, srst (sync, active-high) ; push/wdata ; pop/rdata (head) ; full, empty
module fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_s, pop_s;

    // Status flags, qualified operations and next pointer/count values.
    always_comb begin
        full     = (count_q == (AW+1)'(DEPTH));
        empty    = (count_q == {(AW+1){1'b0}});
        push_s   = push && !full;
        pop_s    = pop && !empty;
        rdata    = mem_q[rd_ptr_q];
        wr_ptr_d = push_s ? wr_ptr_q + {{(AW-1){1'b0}}, 1'b1} : wr_ptr_q;
        rd_ptr_d = pop_s  ? rd_ptr_q + {{(AW-1){1'b0}}, 1'b1} : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one output.  Grant is combinational from the
// registered pointer; the pointer moves past the winner only when en is high.
//   clk, reset (sync, active-low) ; req[N] ; en (slot free) ; gnt_idx, gnt_valid
module rr_arbiter
    import switch_pkg::*;
#(
    parameter  int N  = 8,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    logic [IW-1:0]     ptr_q, ptr_d;
    logic [RR_MAX-1:0] req_ext_s;
    rr_pick_t          pick_s;

    // Pick the winner and compute the pointer that follows it.
    always_comb begin
        req_ext_s         = {RR_MAX{1'b0}};
        req_ext_s[N-1:0]  = req;
        pick_s            = rr_pick(req_ext_s, 32'(ptr_q), 32'(N));
        // A pick outside the port range is treated as no grant.
        gnt_valid         = pick_s.valid && (pick_s.idx < 32'(N));
        gnt_idx           = IW'(pick_s.idx);
        if (en && gnt_valid) begin
            if (gnt_idx == IW'(N - 1)) begin
                ptr_d = {IW{1'b0}};
            end else begin
                ptr_d = gnt_idx + IW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= {IW{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rr_switch_fabric.sv
// Input-queued INPUT_QTY x OUTPUT_QTY switch: per-input FIFO, per-output
// round-robin arbiter, registered valid/ready output slots.
//   clk, reset (sync, active-low)
//   in_valid/in_ready/in_data/in_dest   : ingress handshake per input
//   out_valid/out_ready/out_data/out_src: egress handshake per output
module rr_switch_fabric
    import switch_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int INPUT_QTY  = INPUT_QTY_DEF,
    parameter  int OUTPUT_QTY = OUTPUT_QTY_DEF,
    parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int SRC_W      = $clog2(INPUT_QTY),
    localparam int DEST_W     = $clog2(OUTPUT_QTY)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [INPUT_QTY-1:0]                  in_valid,
    output logic [INPUT_QTY-1:0]                  in_ready,
    input  logic [INPUT_QTY-1:0][DATA_WIDTH-1:0]  in_data,
    input  logic [INPUT_QTY-1:0][DEST_W-1:0]      in_dest,
    output logic [OUTPUT_QTY-1:0]                 out_valid,
    input  logic [OUTPUT_QTY-1:0]                 out_ready,
    output logic [OUTPUT_QTY-1:0][DATA_WIDTH-1:0] out_data,
    output logic [OUTPUT_QTY-1:0][SRC_W-1:0]      out_src
);

    localparam int FIFO_W = DATA_WIDTH + DEST_W;

    logic [INPUT_QTY-1:0]                  full_s, empty_s, push_s, pop_s;
    logic [INPUT_QTY-1:0][DATA_WIDTH-1:0]  head_data_s;
    logic [INPUT_QTY-1:0][DEST_W-1:0]      head_dest_s;
    logic [OUTPUT_QTY-1:0][INPUT_QTY-1:0]  req_s;
    logic [OUTPUT_QTY-1:0]                 slot_free_s, gnt_valid_s;
    logic [OUTPUT_QTY-1:0][SRC_W-1:0]      gnt_idx_s;

    logic [OUTPUT_QTY-1:0]                 out_valid_q, out_valid_d;
    logic [OUTPUT_QTY-1:0][DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [OUTPUT_QTY-1:0][SRC_W-1:0]      out_src_q, out_src_d;

    // Ingress acceptance; words with an unreachable destination are taken and dropped.
    always_comb begin
        if (reset) begin
            in_ready = ~full_s;
        end else begin
            in_ready = {INPUT_QTY{1'b0}};
        end
        for (int i = 0; i < INPUT_QTY; i++) begin
            push_s[i] = in_valid[i] && in_ready[i]
                        && ({1'b0, in_dest[i]} < (DEST_W+1)'(OUTPUT_QTY));
        end
    end

    for (genvar i = 0; i < INPUT_QTY; i++) begin : g_in
        logic [FIFO_W-1:0] rdata_s;

        fifo #(
            .WIDTH (FIFO_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .srst  (~reset),
            .push  (push_s[i]),
            .wdata ({in_data[i], in_dest[i]}),
            .pop   (pop_s[i]),
            .rdata (rdata_s),
            .full  (full_s[i]),
            .empty (empty_s[i])
        );

        assign head_data_s[i] = rdata_s[FIFO_W-1:DEST_W];
        assign head_dest_s[i] = rdata_s[DEST_W-1:0];
    end

    // Each non-empty head requests exactly the output its dest names.
    always_comb begin
        for (int o = 0; o < OUTPUT_QTY; o++) begin
            slot_free_s[o] = !out_valid_q[o] || out_ready[o];
            for (int i = 0; i < INPUT_QTY; i++) begin
                req_s[o][i] = !empty_s[i] && (head_dest_s[i] == DEST_W'(o));
            end
        end
    end

    for (genvar o = 0; o < OUTPUT_QTY; o++) begin : g_out
        rr_arbiter #(
            .N (INPUT_QTY)
        ) u_arb (
            .clk       (clk),
            .reset     (reset),
            .req       (req_s[o]),
            .en        (slot_free_s[o]),
            .gnt_idx   (gnt_idx_s[o]),
            .gnt_valid (gnt_valid_s[o])
        );
    end

    // Pop the granted heads and load the free output slots.
    always_comb begin
        pop_s       = {INPUT_QTY{1'b0}};
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        for (int o = 0; o < OUTPUT_QTY; o++) begin
            if (slot_free_s[o]) begin
                out_valid_d[o] = gnt_valid_s[o];
                if (gnt_valid_s[o]) begin
                    out_data_d[o] = head_data_s[gnt_idx_s[o]];
                    out_src_d[o]  = gnt_idx_s[o];
                    for (int i = 0; i < INPUT_QTY; i++) begin
                        if (gnt_idx_s[o] == SRC_W'(i)) begin
                            pop_s[i] = 1'b1;
                        end else begin
                            pop_s[i] = pop_s[i];
                        end
                    end
                end else begin
                    out_data_d[o] = out_data_q[o];
                end
            end else begin
                out_valid_d[o] = out_valid_q[o];
            end
        end
    end

    // Output slot registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q <= {OUTPUT_QTY{1'b0}};
            out_data_q  <= {(OUTPUT_QTY*DATA_WIDTH){1'b0}};
            out_src_q   <= {(OUTPUT_QTY*SRC_W){1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule
